// File: rtl/pads_out_pkg.sv
// Shared types and defaults for the output-pad sequencer slice.
// Default channel map: [3:0] led, 4 spi_mosi, 5 spi_sck, 6 spi_ss, 7 uart_sout, 8 boot_sequence_done.
package pads_out_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    localparam int unsigned CH_LED0      = 0;
    localparam int unsigned CH_LED1      = 1;
    localparam int unsigned CH_LED2      = 2;
    localparam int unsigned CH_LED3      = 3;
    localparam int unsigned CH_SPI_MOSI  = 4;
    localparam int unsigned CH_SPI_SCK   = 5;
    localparam int unsigned CH_SPI_SS    = 6;
    localparam int unsigned CH_UART_SOUT = 7;
    localparam int unsigned CH_BOOT_DONE = 8;

    localparam int unsigned DEFAULT_N_CH     = 9;
    localparam logic [8:0]  DEFAULT_SAFE_VAL = 9'h0C0;

    // Counter width for a modulo-m counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pads_out_stagger_cnt.sv
// Modulo-MOD counter with synchronous clear; tick marks the last count of each period.
module pads_out_stagger_cnt
    import pads_out_pkg::*;
#(
    parameter int unsigned MOD = 4,
    parameter int unsigned W   = cnt_width(MOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

    always_comb begin
        tick = en && !clr && (cnt == LAST);
    end

endmodule

// File: rtl/pads_out_seq.sv
// Registered output-pad sequencer: safe hold, staggered hand-over to the core, then pass-through.
// Optional walk-test pattern in HOLD under `define PADS_OUT_WALK_TEST_EN. Release request port is release_req (release is reserved).
module pads_out_seq
    import pads_out_pkg::*;
#(
    parameter int unsigned     N_CH        = DEFAULT_N_CH,
    parameter int unsigned     STAGGER_CYC = 4,
    parameter logic [N_CH-1:0] SAFE_VAL    = N_CH'(DEFAULT_SAFE_VAL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            release_req,
    input  logic            force_safe,
`ifdef PADS_OUT_WALK_TEST_EN
    input  logic            walk_test,
`endif
    input  logic [N_CH-1:0] core_i,
    output logic [N_CH-1:0] pad_o,
    output logic [N_CH-1:0] rel_mask,
    output logic            released_all,
    output logic            busy
);

    state_t          state;
    logic            go;
    logic            stag_clr;
    logic            stag_tick;
    logic [N_CH-1:0] mask_shift;
    logic [N_CH-1:0] hold_pat;

    always_comb begin
        go         = release_req && !force_safe;
        stag_clr   = (state != RELEASE) || !go;
        mask_shift = (rel_mask << 1) | N_CH'(1);
    end

    pads_out_stagger_cnt #(
        .MOD (STAGGER_CYC)
    ) u_stagger (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stag_clr),
        .en    (1'b1),
        .tick  (stag_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD;
            rel_mask     <= '0;
            released_all <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (go) begin
                        rel_mask <= N_CH'(1);
                        // A single channel is fully released by the first grant.
                        if (N_CH == 1) begin
                            state        <= RUN;
                            released_all <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            state        <= RELEASE;
                            released_all <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (!go) begin
                        state        <= HOLD;
                        rel_mask     <= '0;
                        released_all <= 1'b0;
                        busy         <= 1'b0;
                    end else if (stag_tick) begin
                        rel_mask <= mask_shift;
                        if (&mask_shift) begin
                            state        <= RUN;
                            released_all <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!go) begin
                        state        <= HOLD;
                        rel_mask     <= '0;
                        released_all <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= HOLD;
                    rel_mask     <= '0;
                    released_all <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

`ifdef PADS_OUT_WALK_TEST_EN
    logic            walk_active;
    logic            walk_tick;
    logic [N_CH-1:0] walk;

    always_comb begin
        walk_active = (state == HOLD) && walk_test;
    end

    pads_out_stagger_cnt #(
        .MOD (STAGGER_CYC)
    ) u_walk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!walk_active),
        .en    (1'b1),
        .tick  (walk_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk <= N_CH'(1);
        end else if (!walk_active) begin
            walk <= N_CH'(1);
        end else if (walk_tick) begin
            walk <= (walk << 1) | (walk >> (N_CH - 1));
        end
    end

    always_comb begin
        hold_pat = walk_active ? (SAFE_VAL ^ walk) : SAFE_VAL;
    end
`else
    always_comb begin
        hold_pat = SAFE_VAL;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_o <= SAFE_VAL;
        end else begin
            pad_o <= (rel_mask & core_i) | (~rel_mask & hold_pat);
        end
    end

endmodule

// File: tb/tb_pads_out_seq.sv
// Directed bench for pads_out_seq with default parameters (N_CH=9, STAGGER_CYC=4, SAFE_VAL=9'h0C0).
module tb_pads_out_seq;

    logic       clk;
    logic       rst_n;
    logic       release_req;
    logic       force_safe;
    logic [8:0] core_i;
    logic [8:0] pad_o;
    logic [8:0] rel_mask;
    logic       released_all;
    logic       busy;

    int         checks;
    int         errors;
    int         nb;
    logic [8:0] exp_mask;
    logic [8:0] prev_mask;
    logic [8:0] exp_pad;

    localparam logic [8:0] SAFE = 9'h0C0;

    pads_out_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .release_req  (release_req),
        .force_safe   (force_safe),
        .core_i       (core_i),
        .pad_o        (pad_o),
        .rel_mask     (rel_mask),
        .released_all (released_all),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        release_req = 1'b0;
        force_safe  = 1'b0;
        core_i      = 9'h1FF;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pad", pad_o, 9'h0C0);
        chk("rst_mask", rel_mask, 9'h000);
        chk("rst_all", {8'b0, released_all}, 9'h000);
        chk("rst_busy", {8'b0, busy}, 9'h000);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("hold_pad", pad_o, 9'h0C0);
        chk("hold_mask", rel_mask, 9'h000);

        // force_safe wins over release in HOLD
        release_req = 1'b1;
        force_safe  = 1'b1;
        step(3);
        chk("prio_mask", rel_mask, 9'h000);
        chk("prio_busy", {8'b0, busy}, 9'h000);
        chk("prio_pad", pad_o, 9'h0C0);

        // staggered release; edge e below is E0+e
        core_i     = 9'h13F;
        force_safe = 1'b0;
        prev_mask  = 9'h000;
        for (int e = 0; e <= 33; e++) begin
            step(1);
            nb = e / 4 + 1;
            if (nb > 9) nb = 9;
            exp_mask = 9'((1 << nb) - 1);
            exp_pad  = (core_i & prev_mask) | (SAFE & ~prev_mask);
            chk($sformatf("stag_mask_e%0d", e), rel_mask, exp_mask);
            chk($sformatf("stag_pad_e%0d", e), pad_o, exp_pad);
            chk($sformatf("stag_busy_e%0d", e), {8'b0, busy}, {8'b0, (e < 32)});
            chk($sformatf("stag_all_e%0d", e), {8'b0, released_all}, {8'b0, (e >= 32)});
            if (e == 1)  chk("stag_pad_e1_hand", pad_o, 9'h0C1);
            if (e == 5)  chk("stag_pad_e5_hand", pad_o, 9'h0C3);
            if (e == 24) chk("stag_pad_e24_hand", pad_o, 9'h0FF);
            if (e == 25) chk("stag_pad_e25_hand", pad_o, 9'h0BF);
            if (e == 32) chk("stag_mask_e32_hand", rel_mask, 9'h1FF);
            if (e == 33) chk("stag_pad_e33_hand", pad_o, 9'h13F);
            prev_mask = exp_mask;
        end

        // RUN pass-through latency
        core_i = 9'h000;
        step(1);
        chk("run_pad_000", pad_o, 9'h000);
        core_i = 9'h155;
        @(negedge clk);
        chk("run_pad_early", pad_o, 9'h000);
        step(1);
        chk("run_pad_155", pad_o, 9'h155);

        // force_safe pulse in RUN, then restagger
        force_safe = 1'b1;
        step(1);
        chk("fs_mask", rel_mask, 9'h000);
        chk("fs_all", {8'b0, released_all}, 9'h000);
        chk("fs_pad_same_edge", pad_o, 9'h155);
        force_safe = 1'b0;
        step(1);
        chk("fs_pad_safe", pad_o, 9'h0C0);
        chk("fs_restart_mask", rel_mask, 9'h001);
        chk("fs_restart_busy", {8'b0, busy}, 9'h001);

        // abort mid-RELEASE at E0+10
        step(8);
        chk("abort_mask_e8", rel_mask, 9'h007);
        step(1);
        release_req = 1'b0;
        step(1);
        chk("abort_mask", rel_mask, 9'h000);
        chk("abort_busy", {8'b0, busy}, 9'h000);
        chk("abort_pad_same_edge", pad_o, 9'h0C5);
        step(1);
        chk("abort_pad_safe", pad_o, 9'h0C0);

        // re-raise restarts from channel 0; unreleased core bits are ignored
        release_req = 1'b1;
        core_i      = 9'h1FE;
        step(1);
        chk("rerun_mask", rel_mask, 9'h001);
        chk("rerun_pad_e0", pad_o, 9'h0C0);
        step(1);
        chk("unrel_pad", pad_o, 9'h0C0);
        core_i = 9'h1FF;
        step(1);
        chk("rel0_pad", pad_o, 9'h0C1);

        // asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("async_pad", pad_o, 9'h0C0);
        chk("async_mask", rel_mask, 9'h000);
        chk("async_busy", {8'b0, busy}, 9'h000);
        rst_n = 1'b1;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
